// File: rtl/countdown_timer.sv
// countdown_timer: loadable N-bit down-counter with a one-cycle done pulse,
// optional auto-reload for periodic ticks, pause and restart.
module countdown_timer #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] count_q, count_n;
  logic         load_zero;

  assign load_zero = (load_val == '0);

  // State and counter registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count_q <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
    end
  end

  // Next-state and next-count; priority is start > pause > decrement.
  always_comb begin
    state_n = state;
    count_n = count_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          count_n = load_val;
          state_n = load_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (start) begin
          count_n = load_val;
          state_n = load_zero ? DONE : RUN;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (count_q > N'(1)) begin
          count_n = count_q - N'(1);
        end else begin
          // count_q of 0 is unreachable in RUN; treat it like 1 so the
          // counter can never wrap below zero.
          count_n = '0;
          state_n = DONE;
        end
      end
      PAUSE: begin
        if (start) begin
          count_n = load_val;
          state_n = load_zero ? DONE : RUN;
        end else if (!pause) begin
          // Resume edge only re-enters RUN; decrementing restarts next edge.
          state_n = RUN;
        end
      end
      DONE: begin
        count_n = '0;
        if (start) begin
          count_n = load_val;
          state_n = load_zero ? DONE : RUN;
        end else if (auto_reload && !load_zero) begin
          count_n = load_val;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    count = count_q;
    busy  = (state == RUN) || (state == PAUSE);
    done  = (state == DONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (N=6).
module tb_countdown_timer;

  localparam int unsigned N = 6;

  logic         clk;
  logic         reset;
  logic         start;
  logic         pause;
  logic         auto_reload;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int total;
  int bad;

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Advance one active edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; auto_reload = 1'b0; load_val = '0;
    #2;
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b want count=0 busy=0 done=0", count, busy, done);
    end
    #8;
    reset = 1'b0;
    tick();
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_single_shot();
    int busy_cycles;
    busy_cycles = 0;
    load_val = 6'b010100;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_val = 6'd7; // must not affect the running count
    if (busy === 1'b1) busy_cycles++;
    total++;
    if (count !== 6'd20 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_load: count=%0d busy=%b done=%b want 20/1/0", count, busy, done);
    end
    for (int i = 19; i >= 1; i--) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      total++;
      if (count !== 6'(i) || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL single_step: count=%0d busy=%b done=%b want %0d/1/0", count, busy, done, i);
      end
    end
    tick();
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL single_done: count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
    end
    total++;
    if (busy_cycles != 20) begin
      bad++;
      $display("FAIL single_busy_len: busy cycles=%0d want 20", busy_cycles);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL single_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
      end
    end
  endtask

  task automatic test_auto_reload();
    load_val = 6'd5;
    auto_reload = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (count !== 6'd5 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL auto_load: count=%0d busy=%b done=%b want 5/1/0", count, busy, done);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 4; i >= 1; i--) begin
        tick();
        total++;
        if (count !== 6'(i) || busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL auto_step: period=%0d count=%0d busy=%b done=%b want %0d/1/0", p, count, busy, done, i);
        end
      end
      tick();
      total++;
      if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL auto_done: period=%0d count=%0d busy=%b done=%b want 0/0/1", p, count, busy, done);
      end
      if (p == 2) auto_reload = 1'b0;
      tick();
      if (p < 2) begin
        total++;
        if (count !== 6'd5 || busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL auto_reload: period=%0d count=%0d busy=%b done=%b want 5/1/0", p, count, busy, done);
        end
      end else begin
        total++;
        if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL auto_stop: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
        end
      end
    end
  endtask

  task automatic test_pause();
    int latency;
    int exp_cnt;
    bit seen_done;
    latency = 0;
    seen_done = 0;
    load_val = 6'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 19; i >= 14; i--) begin
      tick();
      latency++;
    end
    total++;
    if (count !== 6'd14) begin
      bad++;
      $display("FAIL pause_pre: count=%0d want 14", count);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      latency++;
      total++;
      if (count !== 6'd14 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold: cycle=%0d count=%0d busy=%b done=%b want 14/1/0", i, count, busy, done);
      end
    end
    pause = 1'b0;
    tick();
    latency++;
    total++;
    if (count !== 6'd14 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pause_resume: count=%0d busy=%b want 14/1", count, busy);
    end
    exp_cnt = 13;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      tick();
      latency++;
      if (done === 1'b1) begin
        seen_done = 1;
      end else begin
        total++;
        if (count !== 6'(exp_cnt)) begin
          bad++;
          $display("FAIL pause_count: count=%0d want %0d", count, exp_cnt);
        end
        exp_cnt--;
      end
    end
    total++;
    if (!seen_done || latency != 25) begin
      bad++;
      $display("FAIL pause_latency: seen_done=%0d edges=%0d want 1 and 25", seen_done, latency);
    end
    // pause has no effect in IDLE
    pause = 1'b1;
    tick();
    tick();
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL pause_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
    pause = 1'b0;
  endtask

  task automatic test_restart();
    load_val = 6'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++;
    if (count !== 6'd9) begin
      bad++;
      $display("FAIL restart_pre: count=%0d want 9", count);
    end
    load_val = 6'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (count !== 6'd3 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_load: count=%0d busy=%b done=%b want 3/1/0", count, busy, done);
    end
    for (int i = 2; i >= 1; i--) begin
      tick();
      total++;
      if (count !== 6'(i) || done !== 1'b0) begin
        bad++;
        $display("FAIL restart_step: count=%0d done=%b want %0d/0", count, done, i);
      end
    end
    tick();
    total++;
    if (count !== 6'd0 || done !== 1'b1) begin
      bad++;
      $display("FAIL restart_done: count=%0d done=%b want 0/1", count, done);
    end
    tick();
  endtask

  task automatic test_zero_load();
    load_val = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_val = 6'd9;
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: count=%0d busy=%b done=%b want 0/0/1", count, busy, done);
    end
    tick();
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_async_reset();
    load_val = 6'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++;
    if (count !== 6'd12) begin
      bad++;
      $display("FAIL areset_pre: count=%0d want 12", count);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL areset_idle: count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_shot();
    test_auto_reload();
    test_pause();
    test_restart();
    test_zero_load();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, parameterizable down-counter: the down-counting counterpart of the team's wrap-to-max up counter.
- Loads a start value, decrements once per clock to zero, then emits a one-cycle done pulse.
- Optional auto-reload turns it into a periodic tick generator.
- Supports pause and restart. Feeds timeouts and periodic strobes in the top-level datapath.

Parameters:
- N, 6, counter width in bits. Legal load values are 0 to 2^N-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  load load_val and begin counting; sampled each rising edge
- pause  input  1  while high, count holds
- auto_reload  input  1  when high, reload load_val after reaching zero and keep running
- load_val  input  N  value loaded on start or reload
- count  output  N  current counter value
- busy  output  1  high in RUN or PAUSE
- done  output  1  one-cycle pulse, high for exactly the cycle after count reaches 0

Behaviour:
- Reset (async, active-high, any time, including mid-count):
  - State goes to IDLE; count=0, busy=0, done=0 immediately, no clock needed.
  - After reset deasserts, the first active edge acts from IDLE.
- States: IDLE, RUN, PAUSE, DONE. done = (state==DONE). busy = (state==RUN or PAUSE). Both are decoded from registered state, with no combinational input-to-output path.
- Edge priority: reset > start > pause > decrement.
- IDLE:
  - start=1, load_val!=0: count<=load_val, go to RUN.
  - start=1, load_val==0: count<=0, go to DONE (done pulse next cycle).
  - Otherwise hold count and stay in IDLE. After a completed count, count stays 0.
- RUN:
  - start=1: count<=load_val, stay in RUN (restart). If load_val==0, go to DONE.
  - pause=1: go to PAUSE; count does not decrement on this edge.
  - count>1: count<=count-1.
  - count==1: count<=0, go to DONE.
- PAUSE:
  - start=1: restart as in RUN.
  - pause=1: hold.
  - pause=0: go to RUN, with no decrement on this edge. Decrement resumes on the following edge.
- DONE (always exactly one cycle, count==0):
  - start=1: restart as in IDLE.
  - auto_reload=1 and load_val!=0: count<=load_val, go to RUN.
  - Otherwise go to IDLE.
- Timing:
  - Single shot from start edge with load value L>=1: count shows L, L-1, ..., 1, 0. done is high during the cycle count==0, L+1 edges after the start edge.
  - Auto-reload period is L+1 cycles per done pulse.
- load_val is sampled only on start or reload edges. Changes at other times have no effect on the running count.
- Arithmetic is unsigned N-bit. The counter never decrements below 0 and never wraps.
- pause is ignored in IDLE and DONE.

Test Plan:
1. Reset on for 10 time units, then start=1 for one cycle with load_val=20 (6'b010100), auto_reload=0 -> count steps 20 down to 0 on consecutive edges; busy=1 for 20 cycles; done high for exactly one cycle when count==0; then IDLE with count=0 and busy=0.
2. load_val=5, auto_reload=1 -> done pulses every 6 cycles, at least 3 periods checked; count sequence is 5,4,3,2,1,0,5,...; busy low only in the DONE cycles.
3. load_val=20; after count reaches 14, pause high for 4 cycles -> count holds 14 for the pause cycles plus one resume cycle, then continues to 13; total start-to-done latency is 21+5 cycles.
4. Count running at 9; start with load_val=3 -> count=3 on the next edge, done after 3 further edges; no spurious done at restart.
5. start with load_val=0 -> no RUN phase; done pulses one cycle after the start edge; count stays 0.
6. Assert reset asynchronously between edges while count=12 -> count=0, busy=0, done=0 before the next clock edge. After release, the module stays in IDLE until start.
